// File: rtl/eth_tx_arbiter.sv
// -----------------------------------------------------------------------------
// eth_tx_arbiter
//
// Shares the single MAC transmit byte stream between the ARP reply generator
// and the IPv4 frame builder. One source is granted at a time (round-robin on
// ties), its byte stream is forwarded combinationally with valid/ready, and
// an inter-frame gap is enforced after every frame. Over-length frames are
// truncated (forced m_last + abort) and stalled frames are abandoned (abort
// with no m_last) so a misbehaving source cannot lock up the MAC.
//
// Parameters
//   IFG_CYCLES      idle cycles after each frame (0 = straight back to IDLE)
//   MAX_FRAME_BYTES bytes per frame before truncation (>= 2)
//   STALL_TIMEOUT   consecutive non-valid cycles tolerated inside a frame (>= 1)
//
// Ports
//   aclk, aresetn             clock, asynchronous active-low reset
//   arp_req/gnt               ARP source request / ownership of the stream
//   arp_data/valid/last/ready ARP byte stream
//   ip_*                      same set for the IPv4 source
//   m_data/valid/last/ready   byte stream towards the MAC framer
//   busy                      high whenever the FSM is not IDLE
//   abort                     one-cycle pulse: current frame truncated/abandoned
// -----------------------------------------------------------------------------
module eth_tx_arbiter #(
   parameter int IFG_CYCLES      = 12,
   parameter int MAX_FRAME_BYTES = 1514,
   parameter int STALL_TIMEOUT   = 1024
) (
   input  logic       aclk,
   input  logic       aresetn,
   // ARP source
   input  logic       arp_req,
   output logic       arp_gnt,
   input  logic [7:0] arp_data,
   input  logic       arp_valid,
   input  logic       arp_last,
   output logic       arp_ready,
   // IPv4 source
   input  logic       ip_req,
   output logic       ip_gnt,
   input  logic [7:0] ip_data,
   input  logic       ip_valid,
   input  logic       ip_last,
   output logic       ip_ready,
   // MAC side
   output logic [7:0] m_data,
   output logic       m_valid,
   output logic       m_last,
   input  logic       m_ready,
   // status
   output logic       busy,
   output logic       abort
);

   // ---------------------------------------------------------------------------
   // Counter sizing. The IFG counter keeps one bit even when IFG_CYCLES is 0 so
   // the declaration stays legal; it is never used in that configuration.
   // ---------------------------------------------------------------------------
   localparam int BCNT_W = $clog2(MAX_FRAME_BYTES + 1);
   localparam int SCNT_W = $clog2(STALL_TIMEOUT + 1);
   localparam int ICNT_W = (IFG_CYCLES > 0) ? $clog2(IFG_CYCLES + 1) : 1;

   // Terminal values compared against the *current* count, so the terminal
   // action fires in the same cycle as the transfer/idle cycle that reaches it.
   localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(MAX_FRAME_BYTES - 1);
   localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(STALL_TIMEOUT - 1);
   localparam logic [ICNT_W-1:0] ICNT_LAST = ICNT_W'(IFG_CYCLES - 1);

   localparam logic SEL_ARP = 1'b0;
   localparam logic SEL_IP  = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_XFER = 2'd1,
      ST_IFG  = 2'd2
   } state_e;

   state_e            state_q,     state_d;
   logic              last_sel_q,  last_sel_d;
   logic [BCNT_W-1:0] byte_cnt_q,  byte_cnt_d;
   logic [SCNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [ICNT_W-1:0] ifg_cnt_q,   ifg_cnt_d;

   // Source-side view of the currently selected requester. last_sel_q doubles
   // as the grant select: it always names the source that owns XFER.
   logic [7:0] src_data;
   logic       src_valid;
   logic       src_last;
   logic       xfer;
   logic       frame_end;

   assign src_data  = (last_sel_q == SEL_IP) ? ip_data  : arp_data;
   assign src_valid = (last_sel_q == SEL_IP) ? ip_valid : arp_valid;
   assign src_last  = (last_sel_q == SEL_IP) ? ip_last  : arp_last;

   // m_ready is only forwarded to the owner in XFER, so this is the handshake
   // on both sides at once.
   assign xfer = (state_q == ST_XFER) && src_valid && m_ready;

   assign busy = (state_q != ST_IDLE);

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q     <= ST_IDLE;
         last_sel_q  <= SEL_IP;        // ARP wins the first tie after reset
         byte_cnt_q  <= '0;
         stall_cnt_q <= '0;
         ifg_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         last_sel_q  <= last_sel_d;
         byte_cnt_q  <= byte_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         ifg_cnt_q   <= ifg_cnt_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state and outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      last_sel_d  = last_sel_q;
      byte_cnt_d  = byte_cnt_q;
      stall_cnt_d = stall_cnt_q;
      ifg_cnt_d   = ifg_cnt_q;
      frame_end   = 1'b0;

      arp_gnt   = 1'b0;
      arp_ready = 1'b0;
      ip_gnt    = 1'b0;
      ip_ready  = 1'b0;
      m_data    = '0;
      m_valid   = 1'b0;
      m_last    = 1'b0;
      abort     = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (arp_req || ip_req) begin
               if (arp_req && ip_req) begin
                  last_sel_d = ~last_sel_q;   // round-robin on a tie
               end else if (ip_req) begin
                  last_sel_d = SEL_IP;
               end else begin
                  last_sel_d = SEL_ARP;
               end
               state_d     = ST_XFER;
               byte_cnt_d  = '0;
               stall_cnt_d = '0;
            end
         end

         ST_XFER: begin
            if (last_sel_q == SEL_IP) begin
               ip_gnt   = 1'b1;
               ip_ready = m_ready;
            end else begin
               arp_gnt   = 1'b1;
               arp_ready = m_ready;
            end
            m_data  = src_data;
            m_valid = src_valid;
            m_last  = src_last;

            // Backpressure with valid high is not a stall.
            if (src_valid) begin
               stall_cnt_d = '0;
            end

            if (xfer) begin
               byte_cnt_d = byte_cnt_q + BCNT_W'(1);
               if (src_last) begin
                  frame_end = 1'b1;
               end else if (byte_cnt_q == BCNT_LAST) begin
                  // This byte fills the frame: truncate here and let the MAC
                  // framer drop the frame on abort.
                  m_last    = 1'b1;
                  abort     = 1'b1;
                  frame_end = 1'b1;
               end
            end else if (!src_valid) begin
               if (stall_cnt_q == SCNT_LAST) begin
                  // Abandon the frame; no m_last is ever presented for it.
                  m_last    = 1'b0;
                  abort     = 1'b1;
                  frame_end = 1'b1;
               end else begin
                  stall_cnt_d = stall_cnt_q + SCNT_W'(1);
               end
            end

            if (frame_end) begin
               ifg_cnt_d = '0;
               state_d   = (IFG_CYCLES == 0) ? ST_IDLE : ST_IFG;
            end
         end

         ST_IFG: begin
            if (ifg_cnt_q == ICNT_LAST) begin
               state_d = ST_IDLE;
            end else begin
               ifg_cnt_d = ifg_cnt_q + ICNT_W'(1);
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule
